// File: rtl/mips_commit_checker.sv
// rtl/mips_commit_checker.sv - lockstep retire-stream checker for NCH MIPS cores
// Per-channel FIFOs absorb rate skew; heads are compared against channel 0.
module mips_commit_checker #(
  parameter int NCH     = 3,
  parameter int W       = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [NCH-1:0]   commit_valid_i,
  input  logic [NCH*W-1:0] commit_pc_i,
  input  logic [NCH*W-1:0] commit_val_i,
  output logic             compare_fire_o,
  output logic [31:0]      match_count_o,
  output logic             error_o,
  output logic [1:0]       err_code_o,
  output logic [NCH-1:0]   err_mask_o,
  output logic [W-1:0]     err_pc_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW:0] WD_LIMIT = (WDW+1)'(TIMEOUT);

  typedef enum logic {RUN, HALT} state_e;

  state_e         state_q;
  logic [2*W-1:0] mem_q    [NCH][DEPTH];
  logic [AW:0]    wr_ptr_q [NCH];
  logic [AW:0]    rd_ptr_q [NCH];
  logic [WDW-1:0] wd_q, wd_d;
  logic [WDW:0]   wd_inc;

  logic [NCH-1:0] empty, full, push_ok, overflow, mismatch;
  logic [2*W-1:0] head [NCH];
  logic           run, cmp, wd_hit;

  always_comb begin
    empty    = '0;
    full     = '0;
    push_ok  = '0;
    overflow = '0;
    mismatch = '0;
    run      = (state_q == RUN);
    for (int i = 0; i < NCH; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      head[i]  = mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
    cmp = run && !clear_i && (empty == '0);
    for (int i = 0; i < NCH; i++) begin
      // A full FIFO still accepts a push when the same cycle pops it.
      push_ok[i]  = run && !clear_i && commit_valid_i[i] && (!full[i] || cmp);
      overflow[i] = run && !clear_i && commit_valid_i[i] && full[i] && !cmp;
    end
    for (int i = 1; i < NCH; i++) begin
      mismatch[i] = cmp && (head[i] != head[0]);
    end
  end

  always_comb begin
    wd_inc = {1'b0, wd_q} + 1'b1;
    wd_d   = wd_q;
    if (clear_i || cmp || (&empty)) begin
      wd_d = '0;
    end else if (run && ({1'b0, wd_q} != WD_LIMIT)) begin
      wd_d = wd_inc[WDW-1:0];
    end
    wd_hit = (TIMEOUT > 0) && run && !clear_i && !cmp && !(&empty) &&
             (wd_inc == WD_LIMIT);
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCH; i++) begin
      if (push_ok[i]) begin
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= {commit_pc_i[i*W +: W], commit_val_i[i*W +: W]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= RUN;
      wd_q           <= '0;
      compare_fire_o <= 1'b0;
      match_count_o  <= '0;
      error_o        <= 1'b0;
      err_code_o     <= 2'b00;
      err_mask_o     <= '0;
      err_pc_o       <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      compare_fire_o <= cmp;
      wd_q           <= wd_d;
      for (int i = 0; i < NCH; i++) begin
        if (clear_i) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (cmp)        rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
      end
      if (cmp && (mismatch == '0) && (match_count_o != 32'hFFFF_FFFF)) begin
        match_count_o <= match_count_o + 32'd1;
      end
      case (state_q)
        RUN: begin
          // Only the highest-priority event of the first failing cycle is kept.
          if (clear_i) begin
            error_o    <= 1'b0;
            err_code_o <= 2'b00;
            err_mask_o <= '0;
            err_pc_o   <= '0;
          end else if (mismatch != '0) begin
            state_q    <= HALT;
            error_o    <= 1'b1;
            err_code_o <= 2'b01;
            err_mask_o <= mismatch;
            err_pc_o   <= head[0][2*W-1:W];
          end else if (overflow != '0) begin
            state_q    <= HALT;
            error_o    <= 1'b1;
            err_code_o <= 2'b10;
            err_mask_o <= overflow;
            err_pc_o   <= '0;
          end else if (wd_hit) begin
            state_q    <= HALT;
            error_o    <= 1'b1;
            err_code_o <= 2'b11;
            err_mask_o <= empty;
            err_pc_o   <= '0;
          end
        end
        HALT: begin
          if (clear_i) begin
            state_q    <= RUN;
            error_o    <= 1'b0;
            err_code_o <= 2'b00;
            err_mask_o <= '0;
            err_pc_o   <= '0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_commit_checker.sv
// tb/tb_mips_commit_checker.sv - scoreboard bench for mips_commit_checker
// Queue-based reference model predicts each compare and each latched error.
module tb_mips_commit_checker;
  localparam int NCH = 3, W = 32, DEPTH = 8, TIMEOUT = 16;

  logic             clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [NCH-1:0]   valid = '0;
  logic [NCH*W-1:0] pc_bus = '0, val_bus = '0;
  logic             compare_fire, error;
  logic [31:0]      match_count;
  logic [1:0]       err_code;
  logic [NCH-1:0]   err_mask;
  logic [W-1:0]     err_pc;

  mips_commit_checker #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .commit_valid_i(valid), .commit_pc_i(pc_bus), .commit_val_i(val_bus),
    .compare_fire_o(compare_fire), .match_count_o(match_count), .error_o(error),
    .err_code_o(err_code), .err_mask_o(err_mask), .err_pc_o(err_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]    mc;
    logic           err;
    logic [1:0]     code;
    logic [NCH-1:0] mask;
    logic [W-1:0]   pc;
  } exp_t;

  int   checks = 0, errors = 0, fires = 0;
  exp_t cmp_q[$];
  exp_t err_q[$];

  logic [2*W-1:0] mq [NCH][$];
  bit             m_halt = 0, m_err = 0;
  int unsigned    m_mc = 0;
  int             m_wd = 0;
  logic [1:0]     m_code = 0;
  logic [NCH-1:0] m_mask = 0, m_acc = 0;
  logic [W-1:0]   m_pc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic latch(input logic [1:0] code, input logic [NCH-1:0] mask, input logic [W-1:0] pc);
    exp_t e;
    m_halt = 1; m_err = 1; m_code = code; m_mask = mask; m_pc = pc;
    e.mc = m_mc; e.err = 1'b1; e.code = code; e.mask = mask; e.pc = pc;
    err_q.push_back(e);
  endtask

  task automatic model_cycle(input logic [NCH-1:0] v, input logic [NCH*W-1:0] pcb,
                             input logic [NCH*W-1:0] vb, input bit clr);
    bit             cmp, active, to;
    logic [NCH-1:0] mis, ovf, emp;
    logic [2*W-1:0] h0;
    logic [W-1:0]   h0pc;
    exp_t           e;
    active = !m_halt && !clr;
    mis = '0; ovf = '0; emp = '0; to = 0; h0pc = '0; m_acc = '0;
    for (int i = 0; i < NCH; i++) emp[i] = (mq[i].size() == 0);
    cmp = active && (emp == '0);
    if (cmp) begin
      h0 = mq[0][0];
      h0pc = h0[2*W-1:W];
      for (int i = 1; i < NCH; i++) if (mq[i][0] != h0) mis[i] = 1'b1;
    end
    if (active)
      for (int i = 0; i < NCH; i++)
        if (v[i] && mq[i].size() == DEPTH && !cmp) ovf[i] = 1'b1;
    if (clr || cmp || emp == '1) m_wd = 0;
    else if (!m_halt && m_wd < TIMEOUT) begin
      m_wd++;
      to = (m_wd == TIMEOUT);
    end
    if (clr) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_halt = 0; m_err = 0; m_code = 0; m_mask = 0; m_pc = 0;
    end else if (active) begin
      if (cmp) for (int i = 0; i < NCH; i++) void'(mq[i].pop_front());
      for (int i = 0; i < NCH; i++)
        if (v[i] && mq[i].size() < DEPTH) begin
          mq[i].push_back({pcb[i*W +: W], vb[i*W +: W]});
          m_acc[i] = 1'b1;
        end
      if (cmp && mis == '0 && m_mc != 32'hFFFF_FFFF) m_mc++;
      if (mis != '0)      latch(2'b01, mis, h0pc);
      else if (ovf != '0) latch(2'b10, ovf, '0);
      else if (to)        latch(2'b11, emp, '0);
      if (cmp) begin
        e.mc = m_mc; e.err = m_err; e.code = m_code; e.mask = m_mask; e.pc = m_pc;
        cmp_q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic [NCH-1:0] v, input logic [NCH*W-1:0] pcb,
                      input logic [NCH*W-1:0] vb, input bit clr);
    @(negedge clk);
    valid = v; pc_bus = pcb; val_bus = vb; clear = clr;
    model_cycle(v, pcb, vb, clr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_err;
    prev_err = 0;
    forever begin
      @(posedge clk);
      #1;
      if (compare_fire) begin
        fires++;
        if (cmp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_compare: got compare_fire=1 expected no compare");
        end else begin
          e = cmp_q.pop_front();
          chk("cmp_match_count", match_count, e.mc);
          chk("cmp_error", error, e.err);
          chk("cmp_err_code", err_code, e.code);
          chk("cmp_err_mask", err_mask, e.mask);
          chk("cmp_err_pc", err_pc, e.pc);
        end
      end
      if (error && !prev_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_error: got err_code=%0h expected no error", err_code);
        end else begin
          e = err_q.pop_front();
          chk("err_code", err_code, e.code);
          chk("err_mask", err_mask, e.mask);
          chk("err_pc", err_pc, e.pc);
        end
      end
      prev_err = error;
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000ns");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [NCH*W-1:0] pcb, vb;
    logic [NCH-1:0]   v;
    int               cnt[NCH];
    int               seq[NCH];
    int               rate[NCH];
    int               f0, halt_cnt;
    bit               clr;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("rst_compare_fire", compare_fire, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_mask", err_mask, 0);
    chk("rst_err_pc", err_pc, 0);

    f0 = fires;
    for (int k = 0; k < 10; k++)
      step('1, {NCH{W'(32'h0040_0000 + 4*k)}}, {NCH{W'(k)}}, 1'b0);
    idle(3);
    settle();
    chk("match_fires", fires - f0, 10);
    chk("match_count", match_count, 10);
    chk("match_error", error, 0);

    f0 = fires;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int t = 0; t < 30; t++) begin
      v = '0; pcb = '0; vb = '0;
      for (int i = 0; i < NCH; i++) begin
        pcb[i*W +: W] = W'(32'h0040_0000 + 4*cnt[i]);
        vb[i*W +: W]  = W'(cnt[i]);
      end
      if (cnt[0] < 6)                 v[0] = 1'b1;
      if (cnt[1] < 6 && t % 2 == 0)   v[1] = 1'b1;
      if (cnt[2] < 6 && t % 5 == 0)   v[2] = 1'b1;
      step(v, pcb, vb, 1'b0);
      for (int i = 0; i < NCH; i++) if (v[i]) cnt[i]++;
    end
    idle(3);
    settle();
    chk("skew_fires", fires - f0, 6);
    chk("skew_match_count", match_count, 16);
    chk("skew_error", error, 0);

    for (int k = 0; k < 6; k++) begin
      pcb = {NCH{W'(32'h0040_0000 + 4*k)}};
      vb  = {NCH{W'(32'h0F + k)}};
      if (k == 3) vb[2*W +: W] = W'(32'h13);
      step('1, pcb, vb, 1'b0);
    end
    idle(2);
    settle();
    chk("mis_error", error, 1);
    chk("mis_err_code", err_code, 2'b01);
    chk("mis_err_mask", err_mask, 3'b100);
    chk("mis_err_pc", err_pc, 32'h0040_000C);
    chk("mis_match_count", match_count, 19);
    for (int k = 0; k < 4; k++) step('1, {NCH{W'(32'h500 + 4*k)}}, {NCH{W'(k)}}, 1'b0);
    idle(2);
    settle();
    chk("halt_match_count", match_count, 19);
    chk("halt_err_code", err_code, 2'b01);
    step('0, '0, '0, 1'b1);
    settle();
    chk("clr_error", error, 0);
    chk("clr_err_code", err_code, 0);
    chk("clr_err_mask", err_mask, 0);
    chk("clr_err_pc", err_pc, 0);
    chk("clr_match_count", match_count, 19);

    for (int k = 0; k < 8; k++) step(3'b100, {NCH{W'(32'h900 + 4*k)}}, {NCH{W'(k)}}, 1'b0);
    settle();
    chk("ovf_full_no_error", error, 0);
    step(3'b100, {NCH{W'(32'h900 + 32)}}, {NCH{W'(8)}}, 1'b0);
    settle();
    chk("ovf_error", error, 1);
    chk("ovf_err_code", err_code, 2'b10);
    chk("ovf_err_mask", err_mask, 3'b100);
    step('0, '0, '0, 1'b1);
    for (int k = 0; k < 7; k++) step(3'b100, {NCH{W'(32'h900 + 4*k)}}, {NCH{W'(k)}}, 1'b0);
    pcb = {NCH{W'(32'h900)}};  vb = {NCH{W'(0)}};
    pcb[2*W +: W] = W'(32'h900 + 28); vb[2*W +: W] = W'(7);
    step('1, pcb, vb, 1'b0);
    step(3'b100, {NCH{W'(32'h900 + 32)}}, {NCH{W'(8)}}, 1'b0);
    settle();
    chk("ovf_pop_no_error", error, 0);
    chk("ovf_pop_match_count", match_count, 20);
    step('0, '0, '0, 1'b1);

    step(3'b001, {NCH{W'(32'hA00)}}, {NCH{W'(1)}}, 1'b0);
    idle(15);
    settle();
    chk("to_early_error", error, 0);
    idle(1);
    settle();
    chk("to_error", error, 1);
    chk("to_err_code", err_code, 2'b11);
    chk("to_err_mask", err_mask, 3'b110);
    step('0, '0, '0, 1'b1);
    settle();
    chk("to_clr_error", error, 0);
    chk("to_clr_match_count", match_count, 20);

    halt_cnt = 0;
    for (int i = 0; i < NCH; i++) begin seq[i] = 0; rate[i] = 50; end
    for (int t = 0; t < 600; t++) begin
      if (t % 64 == 0)
        for (int i = 0; i < NCH; i++)
          case ($urandom_range(0, 3))
            0: rate[i] = 5;
            1: rate[i] = 40;
            2: rate[i] = 70;
            default: rate[i] = 100;
          endcase
      clr = (m_halt && halt_cnt >= 4) || ($urandom_range(0, 199) == 0);
      v = '0;
      for (int i = 0; i < NCH; i++) begin
        v[i] = !clr && ($urandom_range(0, 99) < rate[i]);
        pcb[i*W +: W] = W'(32'h1000 + 4*seq[i]);
        vb[i*W +: W]  = W'(3*seq[i]) ^ W'($urandom_range(0, 79) == 0);
      end
      step(v, pcb, vb, clr);
      if (clr) for (int i = 0; i < NCH; i++) seq[i] = 0;
      else     for (int i = 0; i < NCH; i++) if (m_acc[i]) seq[i]++;
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end
    step('0, '0, '0, 1'b1);
    idle(2);
    settle();
    chk("cmp_queue_drained", cmp_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);

    for (int k = 0; k < 3; k++) step('1, {NCH{W'(32'hC00 + 4*k)}}, {NCH{W'(k)}}, 1'b0);
    step(3'b001, {NCH{W'(32'hC0C)}}, {NCH{W'(3)}}, 1'b0);
    settle();
    @(negedge clk);
    valid = '0; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_compare_fire", compare_fire, 0);
    chk("arst_match_count", match_count, 0);
    chk("arst_error", error, 0);
    chk("arst_err_code", err_code, 0);
    chk("arst_err_mask", err_mask, 0);
    chk("arst_err_pc", err_pc, 0);
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_halt = 0; m_err = 0; m_mc = 0; m_wd = 0; m_code = 0; m_mask = 0; m_pc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step('1, {NCH{W'(32'hD00)}}, {NCH{W'(7)}}, 1'b0);
    idle(2);
    settle();
    chk("post_rst_match_count", match_count, 1);
    chk("post_rst_error", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
